// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment vectors are ordered GFEDCBA (bit 6 = G, bit 0 = A), active low.
package seg7_scan_ctrl_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic       DP_OFF  = 1'b1;

  // Phase within one digit slot: anodes forced off, then digit driven.
  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_ON    = 1'b1
  } slot_state_e;

  // Width of a counter covering 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex2led.sv
// Combinational hex nibble to active-low seven-segment pattern (GFEDCBA).
module HexToLED
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Glyph table for 0-9, A, b, C, d, E, F.
  always_comb begin
    seg_o = SEG_OFF;
    unique case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment bank.
// One digit is driven per slot; each slot starts with an all-off blanking
// gap. New contents are captured into a pending buffer via valid/ready and
// promoted to the active set only at the end of a full scan.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned NDIG  = 8,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [4*NDIG-1:0] upd_hex,
  input  logic [NDIG-1:0]   upd_en,
  input  logic [NDIG-1:0]   upd_dp,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_tick
);

  localparam int unsigned IW = cnt_width(NDIG);
  localparam int unsigned CW = cnt_width(DIV);

  // Scan position
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  slot_state_e   state_q, state_d;
  logic          slot_end, frame_end;

  // Display buffers
  logic              pend_full_q, pend_full_d;
  logic [4*NDIG-1:0] pend_hex_q, pend_hex_d;
  logic [NDIG-1:0]   pend_en_q, pend_en_d;
  logic [NDIG-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NDIG-1:0] act_hex_q, act_hex_d;
  logic [NDIG-1:0]   act_en_q, act_en_d;
  logic [NDIG-1:0]   act_dp_q, act_dp_d;
  logic              xfer, commit;

  // Output path
  logic [3:0]      sel_hex;
  logic            sel_en, sel_dp;
  logic [NDIG-1:0] sel_an;
  logic [6:0]      seg_dec;
  logic [NDIG-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            tick_q, tick_d;

  assign slot_end  = (cnt_q == CW'(DIV - 1));
  assign frame_end = slot_end && (idx_q == IW'(NDIG - 1));
  assign xfer      = upd_valid && !pend_full_q;
  assign commit    = frame_end && pend_full_q;

  // Slot counter, digit index and slot phase next-state.
  // The phase is derived from the next count so state_q always matches cnt_q.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end
    state_d = (cnt_d < CW'(BLANK)) ? SLOT_BLANK : SLOT_ON;
  end

  // Scan position registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= SLOT_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // Pending capture on handshake; promotion to active at frame end.
  // A capture and a commit never coincide: capture needs an empty buffer.
  always_comb begin
    pend_full_d = pend_full_q;
    pend_hex_d  = pend_hex_q;
    pend_en_d   = pend_en_q;
    pend_dp_d   = pend_dp_q;
    act_hex_d   = act_hex_q;
    act_en_d    = act_en_q;
    act_dp_d    = act_dp_q;
    if (commit) begin
      act_hex_d   = pend_hex_q;
      act_en_d    = pend_en_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end
    if (xfer) begin
      pend_hex_d  = upd_hex;
      pend_en_d   = upd_en;
      pend_dp_d   = upd_dp;
      pend_full_d = 1'b1;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_full_q <= 1'b0;
      pend_hex_q  <= '0;
      pend_en_q   <= '0;
      pend_dp_q   <= '0;
      act_hex_q   <= '0;
      act_en_q    <= '0;
      act_dp_q    <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      pend_hex_q  <= pend_hex_d;
      pend_en_q   <= pend_en_d;
      pend_dp_q   <= pend_dp_d;
      act_hex_q   <= act_hex_d;
      act_en_q    <= act_en_d;
      act_dp_q    <= act_dp_d;
    end
  end

  // Select the current digit's nibble/enable/dp and its anode pattern.
  always_comb begin
    sel_hex = '0;
    sel_en  = 1'b0;
    sel_dp  = 1'b0;
    sel_an  = '1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        sel_hex   = act_hex_q[4*i +: 4];
        sel_en    = act_en_q[i];
        sel_dp    = act_dp_q[i];
        sel_an[i] = 1'b0;
      end
    end
  end

  HexToLED u_hex2led (
    .hex_i (sel_hex),
    .seg_o (seg_dec)
  );

  // Drive pattern for the next cycle: dark during blanking or disabled digit.
  always_comb begin
    an_d   = '1;
    seg_d  = SEG_OFF;
    dp_d   = DP_OFF;
    tick_d = frame_end;
    if (state_q == SLOT_ON && sel_en) begin
      an_d  = sel_an;
      seg_d = seg_dec;
      dp_d  = ~sel_dp;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q   <= '1;
      seg_q  <= SEG_OFF;
      dp_q   <= DP_OFF;
      tick_q <= 1'b0;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;
  assign upd_ready  = ~pend_full_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a small scan geometry.
module tb_seg7_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = NDIG * DIV;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              upd_valid;
  logic              upd_ready;
  logic [4*NDIG-1:0] upd_hex;
  logic [NDIG-1:0]   upd_en;
  logic [NDIG-1:0]   upd_dp;
  logic [NDIG-1:0]   an;
  logic [6:0]        seg;
  logic              dp;
  logic              frame_tick;

  int checks = 0;
  int errors = 0;

  // Reference state: elapsed cycles since scan start plus the two buffers.
  int                m_n;
  logic              m_pend_full;
  logic [4*NDIG-1:0] m_pend_hex, m_act_hex;
  logic [NDIG-1:0]   m_pend_en, m_act_en, m_pend_dp, m_act_dp;
  int                last_tick;
  int                cyc;

  logic [NDIG-1:0] exp_an;
  logic [6:0]      exp_seg;
  logic            exp_dp, exp_tick, exp_ready;

  seg7_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_hex    (upd_hex),
    .upd_en     (upd_en),
    .upd_dp     (upd_dp),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock: predict the registered outputs from the pre-edge
  // reference state and inputs, update the reference, then compare.
  task automatic cycle();
    int pos, dig;
    logic xfer;
    @(posedge clk);
    if (!rst_n) begin
      exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1; exp_tick = 1'b0;
      m_n = 0; m_pend_full = 1'b0;
      m_pend_hex = '0; m_pend_en = '0; m_pend_dp = '0;
      m_act_hex = '0; m_act_en = '0; m_act_dp = '0;
      last_tick = -1;
    end else begin
      pos = m_n % DIV;
      dig = (m_n / DIV) % NDIG;
      exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1;
      if (pos >= BLANK && m_act_en[dig]) begin
        exp_an[dig] = 1'b0;
        exp_seg     = ref_seg(m_act_hex[4*dig +: 4]);
        exp_dp      = !m_act_dp[dig];
      end
      exp_tick = (dig == NDIG - 1) && (pos == DIV - 1);
      xfer = upd_valid && !m_pend_full;
      if (exp_tick && m_pend_full) begin
        m_act_hex = m_pend_hex; m_act_en = m_pend_en; m_act_dp = m_pend_dp;
        m_pend_full = 1'b0;
      end
      if (xfer) begin
        m_pend_hex = upd_hex; m_pend_en = upd_en; m_pend_dp = upd_dp;
        m_pend_full = 1'b1;
      end
      m_n++;
    end
    exp_ready = !m_pend_full;
    cyc++;
    #1;
    chk("an", 32'(an), 32'(exp_an));
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("dp", 32'(dp), 32'(exp_dp));
    chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
    chk("upd_ready", 32'(upd_ready), 32'(exp_ready));
    if (rst_n && frame_tick === 1'b1) begin
      if (last_tick >= 0) chk("tick_period", 32'(cyc - last_tick), 32'(FRAME));
      last_tick = cyc;
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (upd_ready !== 1'b1 && k < 4 * FRAME) begin
      cycle();
      k++;
    end
    chk("ready_timeout", 32'(upd_ready), 32'd1);
  endtask

  task automatic offer(input logic [15:0] h, input logic [3:0] e, input logic [3:0] d);
    upd_hex = h; upd_en = e; upd_dp = d; upd_valid = 1'b1;
    cycle();
    upd_valid = 1'b0;
  endtask

  initial begin
    int k;
    cyc = 0;
    last_tick = -1;
    rst_n = 1'b0; upd_valid = 1'b0; upd_hex = '0; upd_en = '0; upd_dp = '0;
    repeat (3) cycle();
    rst_n = 1'b1;

    // Idle display, dark, ticks every frame
    repeat (70) cycle();

    // Full load with one decimal point
    offer(16'h3A05, 4'b1111, 4'b0100);

    // Second offer with different data while the buffer is full: ignored
    upd_hex = 16'hFFFF; upd_en = 4'b0001; upd_dp = 4'b1111; upd_valid = 1'b1;
    repeat (5) cycle();
    upd_valid = 1'b0;
    repeat (80) cycle();

    // Partial enable: digits 0 and 2 dark
    wait_ready();
    offer(16'h1234, 4'b1010, 4'b0011);
    repeat (100) cycle();

    // Transfer in the boundary cycle itself commits one frame later
    wait_ready();
    k = 0;
    while (!((m_n % DIV == DIV - 1) && ((m_n / DIV) % NDIG == NDIG - 1)) && k < 2 * FRAME) begin
      cycle();
      k++;
    end
    chk("boundary_found", 32'(k < 2 * FRAME), 32'd1);
    offer(16'hBEEF, 4'b1111, 4'b1001);
    repeat (80) cycle();

    // Reset mid-ON slot with the pending buffer full
    wait_ready();
    offer(16'h7654, 4'b1111, 4'b0000);
    k = 0;
    while ((m_n % DIV) != BLANK + 2 && k < 2 * DIV) begin
      cycle();
      k++;
    end
    chk("mid_on_found", 32'(k < 2 * DIV), 32'd1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (40) cycle();

    // Randomised traffic with occasional resets
    repeat (800) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      upd_valid = ($urandom_range(0, 3) == 0);
      upd_hex   = 16'($urandom);
      upd_en    = 4'($urandom);
      upd_dp    = 4'($urandom);
      cycle();
    end
    rst_n = 1'b1; upd_valid = 1'b0;
    repeat (40) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
